// File: rtl/fifo_uart_tx.sv
// Pops words from a synchronous FIFO and serialises each one as an asynchronous
// UART frame: start bit, LSB-first data, optional parity, one or two stop bits.
module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             fifo_read,
  output logic             tx,
  output logic             busy,
  output logic             frame_done,
  output logic [15:0]      frame_count
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {IDLE, READ, LOAD, START, DATA, PARITY_BIT, STOP} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [CW-1:0]    baud_cnt, baud_next;
  logic [BW-1:0]    bit_idx, bit_next;
  logic             parity_bit, parity_next;
  logic             tx_next, read_next, done_next;
  logic             bit_end, last_data, last_stop, fetch;

  assign bit_end   = (baud_cnt == CW'(CLKS_PER_BIT - 1));
  assign last_data = (bit_idx == BW'(WIDTH - 1));
  assign last_stop = (bit_idx == BW'(STOP_BITS - 1));
  assign fetch     = enable && !fifo_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (fetch) state_next = READ;
      READ:       state_next = LOAD;
      LOAD:       state_next = START;
      START:      if (bit_end) state_next = DATA;
      DATA:       if (bit_end && last_data) state_next = (PARITY != 0) ? PARITY_BIT : STOP;
      PARITY_BIT: if (bit_end) state_next = STOP;
      STOP:       if (bit_end && last_stop) state_next = fetch ? READ : IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Next values of every registered output and datapath register; bit_idx
  // doubles as the stop-bit counter so two stop bits need no extra state.
  always_comb begin
    tx_next     = tx;
    read_next   = 1'b0;
    done_next   = 1'b0;
    shift_next  = shift_reg;
    parity_next = parity_bit;
    bit_next    = bit_idx;
    baud_next   = bit_end ? '0 : baud_cnt + 1'b1;
    case (state)
      IDLE: begin
        tx_next   = 1'b1;
        baud_next = '0;
        read_next = fetch;
      end
      READ: baud_next = '0;
      LOAD: begin
        shift_next  = fifo_dout;
        parity_next = (^fifo_dout) ^ (PARITY == 2);
        tx_next     = 1'b0;
        baud_next   = '0;
        bit_next    = '0;
      end
      START: if (bit_end) tx_next = shift_reg[0];
      DATA: begin
        if (bit_end) begin
          if (last_data) begin
            bit_next = '0;
            tx_next  = (PARITY != 0) ? parity_bit : 1'b1;
          end else begin
            bit_next   = bit_idx + 1'b1;
            shift_next = shift_reg >> 1;
            tx_next    = shift_next[0];
          end
        end
      end
      PARITY_BIT: if (bit_end) tx_next = 1'b1;
      STOP: begin
        if (bit_end) begin
          if (last_stop) begin
            done_next = 1'b1;
            read_next = fetch;
            bit_next  = '0;
          end else begin
            bit_next = bit_idx + 1'b1;
          end
        end
      end
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx          <= 1'b1;
      fifo_read   <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      shift_reg   <= '0;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      parity_bit  <= 1'b0;
    end else begin
      tx         <= tx_next;
      fifo_read  <= read_next;
      busy       <= (state_next != IDLE);
      frame_done <= done_next;
      shift_reg  <= shift_next;
      baud_cnt   <= baud_next;
      bit_idx    <= bit_next;
      parity_bit <= parity_next;
      if (done_next) frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: three configurations (no/even/odd parity,
// one or two stop bits) each fed by a behavioural FIFO and checked frame by frame.
module tb_fifo_uart_tx;

  localparam int NI = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [NI-1:0] fifo_empty, fifo_read, tx, busy, frame_done;
  logic [7:0]    fifo_dout [NI];
  logic [15:0]   frame_count [NI];
  logic [7:0]    mem [NI][64];
  int            wp [NI] = '{0, 0, 0};
  int            reads [NI];
  int            bad_reads [NI];
  int            exp_count [NI] = '{0, 0, 0};
  int            checks = 0;
  int            errors = 0;

  typedef struct {
    int          k;
    logic [7:0]  word;
    logic [15:0] bits;
    int          nbits;
    int          edges;
  } vec_t;

  vec_t        vecs [8];
  logic [7:0]  words [4];

  always #5 clk = ~clk;

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty[0]),
    .fifo_dout(fifo_dout[0]), .fifo_read(fifo_read[0]), .tx(tx[0]), .busy(busy[0]),
    .frame_done(frame_done[0]), .frame_count(frame_count[0]));

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(2)) u1 (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty[1]),
    .fifo_dout(fifo_dout[1]), .fifo_read(fifo_read[1]), .tx(tx[1]), .busy(busy[1]),
    .frame_done(frame_done[1]), .frame_count(frame_count[1]));

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(3), .PARITY(2), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty[2]),
    .fifo_dout(fifo_dout[2]), .fifo_read(fifo_read[2]), .tx(tx[2]), .busy(busy[2]),
    .frame_done(frame_done[2]), .frame_count(frame_count[2]));

  // Behavioural FIFO per instance: dout updates the cycle after read is sampled;
  // a read against an empty FIFO is counted so it can be flagged.
  for (genvar g = 0; g < NI; g++) begin : g_fifo
    int rp = 0;
    int rd_cnt = 0;
    int bad_cnt = 0;
    assign fifo_empty[g] = (wp[g] == rp);
    assign reads[g]      = rd_cnt;
    assign bad_reads[g]  = bad_cnt;
    always @(posedge clk or negedge rst) begin
      if (!rst) begin
        rp           <= wp[g];
        fifo_dout[g] <= '0;
      end else if (fifo_read[g]) begin
        rd_cnt <= rd_cnt + 1;
        if (wp[g] == rp) begin
          bad_cnt <= bad_cnt + 1;
        end else begin
          fifo_dout[g] <= mem[g][rp % 64];
          rp           <= rp + 1;
        end
      end
    end
  end

  function automatic int cpb(int k);
    return (k == 2) ? 3 : 4;
  endfunction

  function automatic int stopBits(int k);
    return (k == 1) ? 2 : 1;
  endfunction

  function automatic int frameLen(int k);
    return 9 + ((k != 0) ? 1 : 0) + stopBits(k);
  endfunction

  // Reference frame: bit i is the i-th serial bit on the line.
  function automatic logic [15:0] frameBits(int k, logic [7:0] word);
    logic [15:0] f;
    int          ones;
    int          pos;
    f    = '0;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      f[1 + i] = word[i];
      ones += int'(word[i]);
    end
    pos = 9;
    if (k != 0) begin
      f[pos] = ((ones % 2) == 1) ^ (k == 2);
      pos++;
    end
    for (int s = 0; s < stopBits(k); s++) f[pos + s] = 1'b1;
    return f;
  endfunction

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(int k, logic [7:0] word);
    mem[k][wp[k] % 64] = word;
    wp[k] = wp[k] + 1;
  endtask

  // Waits for the start bit, then checks every cycle of the frame against the
  // expected bit sequence; returns positioned on the frame_done cycle.
  task automatic checkFrame(int k, logic [15:0] bits, int nbits, int exp_edges, int drop_at);
    int         edges;
    int         c;
    logic [2:0] got, want;
    c     = cpb(k);
    edges = 0;
    do begin
      tick();
      edges++;
    end while (tx[k] !== 1'b0 && edges < 100);
    checkOutput($sformatf("u%0d start bit seen", k), 32'(tx[k]), 32'd0);
    if (tx[k] !== 1'b0) return;
    if (exp_edges > 0) checkOutput($sformatf("u%0d start latency", k), edges, exp_edges);
    for (int b = 0; b < nbits; b++) begin
      want = {bits[b], 1'b1, 1'b0};
      got  = want;
      for (int j = 0; j < c; j++) begin
        if (b * c + j == drop_at) enable = 1'b0;
        if ({tx[k], busy[k], frame_done[k]} !== want && got === want)
          got = {tx[k], busy[k], frame_done[k]};
        tick();
      end
      checkOutput($sformatf("u%0d bit %0d tx/busy/done", k, b), 32'(got), 32'(want));
    end
    exp_count[k] = (exp_count[k] + 1) % 65536;
    checkOutput($sformatf("u%0d frame_done", k), 32'(frame_done[k]), 32'd1);
    checkOutput($sformatf("u%0d frame_count", k), 32'(frame_count[k]), exp_count[k]);
  endtask

  task automatic checkIdle(int k, int cycles, string name);
    logic [1:0] got;
    got = 2'b10;
    for (int i = 0; i < cycles; i++) begin
      if ({tx[k], fifo_read[k]} !== 2'b10 && got === 2'b10) got = {tx[k], fifo_read[k]};
      tick();
    end
    checkOutput(name, 32'(got), 32'b10);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int r0, n, edges;

    vecs[0] = '{0, 8'hA5, 16'h034A, 10, 3};
    vecs[1] = '{0, 8'h00, 16'h0200, 10, 3};
    vecs[2] = '{0, 8'hFF, 16'h03FE, 10, 2};
    vecs[3] = '{0, 8'h3C, 16'h0278, 10, 2};
    vecs[4] = '{1, 8'h07, 16'h0E0E, 12, 3};
    vecs[5] = '{1, 8'h03, 16'h0C06, 12, 3};
    vecs[6] = '{2, 8'h07, 16'h040E, 11, 3};
    vecs[7] = '{2, 8'h03, 16'h0606, 11, 3};

    #1 rst = 1'b0;
    tick(2);
    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      checkOutput($sformatf("u%0d reset tx/read/busy/done", k),
                  32'({tx[k], fifo_read[k], busy[k], frame_done[k]}), 32'b1000);
      checkOutput($sformatf("u%0d reset frame_count", k), 32'(frame_count[k]), 32'd0);
    end
    enable = 1'b1;
    tick();

    $display("[TB] directed vectors");
    r0 = 0;
    n  = 0;
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].edges == 3) begin
        r0 = reads[vecs[i].k];
        n  = 1;
        applyStimulus(vecs[i].k, vecs[i].word);
        for (int j = i + 1; j < 8; j++) begin
          if (vecs[j].edges != 2) break;
          applyStimulus(vecs[j].k, vecs[j].word);
          n++;
        end
      end
      checkFrame(vecs[i].k, vecs[i].bits, vecs[i].nbits, vecs[i].edges, -1);
      if (i == 7 || vecs[(i + 1) % 8].edges == 3) begin
        tick();
        checkOutput($sformatf("vec %0d done pulse/busy/empty", i),
                    32'({frame_done[vecs[i].k], busy[vecs[i].k], fifo_empty[vecs[i].k]}), 32'b001);
        checkOutput($sformatf("vec %0d read pulses", i), reads[vecs[i].k] - r0, n);
      end
    end

    $display("[TB] flow control");
    enable = 1'b0;
    applyStimulus(1, 8'h96);
    applyStimulus(1, 8'h41);
    r0 = reads[1];
    checkIdle(1, 30, "u1 disabled stays idle");
    checkOutput("u1 disabled no read", reads[1] - r0, 0);
    enable = 1'b1;
    checkFrame(1, frameBits(1, 8'h96), frameLen(1), 3, 4 * cpb(1));
    tick();
    checkOutput("u1 after drop busy/empty", 32'({busy[1], fifo_empty[1]}), 32'b00);
    checkIdle(1, 40, "u1 no fetch after drop");
    checkOutput("u1 one fetch only", reads[1] - r0, 1);
    enable = 1'b1;
    checkFrame(1, frameBits(1, 8'h41), frameLen(1), 3, -1);
    tick();

    $display("[TB] reset mid-frame");
    applyStimulus(0, 8'h37);
    edges = 0;
    do begin
      tick();
      edges++;
    end while (tx[0] !== 1'b0 && edges < 100);
    tick(4 * cpb(0) + 1);
    checkOutput("u0 bit3 before reset", 32'({tx[0], busy[0]}), 32'b01);
    #2 rst = 1'b0;
    #1;
    checkOutput("u0 async reset tx/busy/read", 32'({tx[0], busy[0], fifo_read[0]}), 32'b100);
    checkOutput("u0 async reset frame_count", 32'(frame_count[0]), 32'd0);
    for (int k = 0; k < NI; k++) exp_count[k] = 0;
    tick();
    rst = 1'b1;
    r0 = reads[0];
    checkIdle(0, 20, "u0 idle after reset");
    checkOutput("u0 no read after reset", reads[0] - r0, 0);
    applyStimulus(0, 8'hC3);
    checkFrame(0, frameBits(0, 8'hC3), frameLen(0), 3, -1);
    tick();

    $display("[TB] random frames");
    for (int k = 0; k < NI; k++) begin
      for (int round = 0; round < 3; round++) begin
        n  = $urandom_range(1, 4);
        r0 = reads[k];
        for (int w = 0; w < n; w++) begin
          words[w] = 8'($urandom);
          applyStimulus(k, words[w]);
        end
        for (int w = 0; w < n; w++)
          checkFrame(k, frameBits(k, words[w]), frameLen(k), (w == 0) ? 3 : 2, -1);
        tick($urandom_range(1, 5));
        checkOutput($sformatf("u%0d random reads/busy", k),
                    32'({16'(reads[k] - r0), 15'd0, busy[k]}), 32'({16'(n), 16'd0}));
      end
    end

    $display("[TB] frame_count wrap");
    force u2.frame_count = 16'hFFFF;
    #1 release u2.frame_count;
    exp_count[2] = 65535;
    tick();
    applyStimulus(2, 8'h5C);
    checkFrame(2, frameBits(2, 8'h5C), frameLen(2), 3, -1);
    tick();

    for (int k = 0; k < NI; k++)
      checkOutput($sformatf("u%0d empty-FIFO reads", k), bad_reads[k], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Downstream consumer of the synchronous FIFO.
- Pops one word at a time through the FIFO's read/dout/fifo_empty interface and serialises it as an asynchronous UART frame on a single line: start bit, data LSB first, optional parity, stop bit(s).
- Sits between the FIFO and the chip's serial output pin.

Parameters:
- WIDTH, 8: data bits per frame; must match the FIFO WIDTH.
- CLKS_PER_BIT, 868: clk cycles per serial bit; must be ≥ 2.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: stop bits per frame, 1 or 2.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  permits fetching new words; a frame already started always completes.
- fifo_empty  input  1  from the FIFO fifo_empty.
- fifo_dout  input  WIDTH  from the FIFO dout; valid the cycle after the FIFO samples read.
- fifo_read  output  1  to the FIFO read; registered, one-cycle pulse per word.
- tx  output  1  serial line; idles high.
- busy  output  1  high in every state except IDLE.
- frame_done  output  1  one-cycle pulse when the last stop bit period ends.
- frame_count  output  16  frames completed since reset; wraps 0xFFFF→0x0000.

Behaviour:
- Reset (rst low, asynchronous):
  - Outputs: tx=1, fifo_read=0, busy=0, frame_done=0, frame_count=0.
  - Internal: state=IDLE, shift register=0, baud counter=0, bit index=0.
- Outputs are registered; no combinational path from any input to any output.
- States and transitions:
  - IDLE: if enable && !fifo_empty at an edge, fifo_read←1 and go to READ. Otherwise stay.
  - READ (1 cycle): fifo_read←0 and go to LOAD. The FIFO samples read=1 at this edge and updates dout.
  - LOAD (1 cycle): at its closing edge, capture fifo_dout into the shift register, compute parity over the captured word, set tx←0, clear the baud counter, and go to START.
  - START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA with tx←bit0.
  - DATA: each bit is held CLKS_PER_BIT cycles, LSB first. After bit WIDTH-1, go to PARITY if PARITY≠0, otherwise go to STOP.
  - PARITY: tx = XOR of the data bits (even), or its inverse (odd), for CLKS_PER_BIT cycles. Then go to STOP.
  - STOP: tx=1 for STOP_BITS×CLKS_PER_BIT cycles. At the final edge:
    - frame_done←1 for one cycle and frame_count←frame_count+1.
    - If enable && !fifo_empty, fifo_read←1 and go directly to READ; otherwise go to IDLE.
- Latency:
  - Sampling edge in IDLE to tx falling: 3 edges (fifo_read high 1 cycle, then READ, then LOAD).
  - Back-to-back frames: exactly 2 idle-high cycles (READ, LOAD) between the end of the stop bit(s) and the next start bit.
- Baud counter: width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1, then advances the bit.
- Bit index: width $clog2(WIDTH+1).
- Boundary conditions:
  - fifo_empty and enable are sampled only in IDLE and at the final STOP edge. Changes mid-frame have no effect.
  - fifo_read is never asserted while fifo_empty=1, so an empty-FIFO read never reaches the FIFO.
  - Deasserting enable mid-frame: the current frame finishes normally, then the block returns to IDLE.
  - Reset mid-frame: tx returns high immediately and the partial frame is abandoned. A word already popped (reset during READ/LOAD or later) is lost; the FIFO shares the reset.
  - frame_count wraps silently; no saturation.
  - fifo_dout is ignored except at the LOAD capture edge.

Test Plan:
- Single word, CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1: write 0xA5 into the FIFO, enable=1 → exactly one fifo_read pulse.
  - tx is low 3 edges later.
  - tx then follows 0,1,0,1,0,0,1,0,1,1, each value held 4 cycles.
  - frame_done pulses once; frame_count=1; busy drops.
- Back-to-back, same configuration: FIFO holds 0x00, 0xFF, 0x3C → three frames, each followed by exactly 2 high cycles before the next start bit.
  - fifo_read pulses exactly 3 times; frame_count=3; fifo_empty=1 at the end.
- Parity, PARITY=1 then PARITY=2, word 0x07 → parity bit 1 (even) / 0 (odd).
  - Word 0x03 → parity bit 0 (even) / 1 (odd).
  - Frame length is 11 bit periods.
- Flow control, STOP_BITS=2:
  - enable=0 with a non-empty FIFO → no fifo_read and tx stays 1.
  - Drop enable mid-DATA → the frame completes with 8 stop cycles and no further fetch.
- Reset mid-frame: assert rst low during DATA bit 3 → tx=1, busy=0, fifo_read=0 and frame_count=0 in the same cycle, without waiting for a clock edge.
  - After release, the block idles until new data is written.
- Wrap: preload frame_count to 0xFFFF via 65535 frames (or a forced preload) → the next frame_done sets frame_count=0x0000.
